// File: rtl/display_pkg.sv
// Shared constants for the hex 7-segment display path: glyph table,
// blank pattern, digit limit and the registered output bundle.
package display_pkg;

    localparam int MAX_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segments, bit0=a .. bit6=g, indexed by nibble value.
    localparam logic [6:0] HEX_GLYPHS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [7:0] anodes;
        logic [6:0] segments;
        logic       dp;
    } disp_out_t;

    localparam disp_out_t DISP_RESET = '{anodes: 8'hFE, segments: 7'h40, dp: 1'b1};

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble to active-low 7-segment glyph decoder.
module hex_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = HEX_GLYPHS[nib_i];
    end

endmodule

// File: rtl/count_display_driver.sv
// Time-multiplexed hex display of a latched N-bit value on an 8-digit
// common-anode 7-segment display, with optional leading-zero blanking.
module count_display_driver
    import display_pkg::*;
#(
    parameter int N           = 32,
    parameter int REFRESH_DIV = 100_000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] value,
    input  logic         update,
    input  logic         blank_zeros,
    output logic [6:0]   segments,
    output logic         dp,
    output logic [7:0]   anodes
);

    localparam int DIGITS = (N + 3) / 4;
    localparam int EXTW   = 4 * MAX_DIGITS;
    localparam int PW     = $clog2(REFRESH_DIV);

    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [2:0]    IDX_LAST   = 3'(DIGITS - 1);

    logic [N-1:0]    shown_q, shown_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [2:0]      idx_q, idx_d;
    disp_out_t       out_q, out_d;

    logic [EXTW-1:0] shown_ext;
    logic [3:0]      nib;
    logic [2:0]      msd;
    logic            blank;
    logic [6:0]      glyph;

    // Zero-extension makes nibbles past the top digit read as 0.
    assign shown_ext = EXTW'(shown_q);
    assign nib       = shown_ext[4*idx_q +: 4];

    always_comb begin
        msd = '0;
        for (int d = 0; d < MAX_DIGITS; d++) begin
            if (shown_ext[4*d +: 4] != 4'h0) begin
                msd = 3'(d);
            end
        end
    end

    hex_to_7seg u_hex_to_7seg (
        .nib_i (nib),
        .seg_o (glyph)
    );

    always_comb begin
        shown_d = update ? value : shown_q;
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end
    end

    // Digit 0 can never be blanked because msd >= 0 always.
    always_comb begin
        blank           = blank_zeros && (idx_q > msd);
        out_d           = DISP_RESET;
        out_d.dp        = 1'b1;
        out_d.anodes    = blank ? 8'hFF : ~(8'h01 << idx_q);
        out_d.segments  = blank ? SEG_BLANK : glyph;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shown_q <= '0;
            presc_q <= '0;
            idx_q   <= '0;
            out_q   <= DISP_RESET;
        end else begin
            shown_q <= shown_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
        end
    end

    assign segments = out_q.segments;
    assign dp       = out_q.dp;
    assign anodes   = out_q.anodes;

endmodule

// File: doc/count_display_driver.md
# count_display_driver

Time-multiplexed 7-segment display driver that consumes the N-bit value produced by the loadable up/down counter and shows it in hexadecimal on the board's 8-digit common-anode display (xc7a100tcsg324-1, 100 MHz). It is the read side of the counter's `counterN` output. It latches the value on request, scans one digit at a time at a fixed refresh rate, and optionally blanks leading zeros.

## Interface
Parameters:
- `N`, 32: width of displayed value; legal range 4..32. Digit count `DIGITS = (N+3)/4`; the top nibble is zero-extended.
- `REFRESH_DIV`, 100_000: clock cycles per digit slot (1 kHz per digit at 100 MHz); legal range ≥ 2.

Ports:
- `clock`  in  1  system clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `value`  in  N  value to display, normally the counter's `counterN`.
- `update`  in  1  when high, `value` is captured into the shadow register at this edge.
- `blank_zeros`  in  1  when high, leading zero digits are unlit.
- `segments`  out  7  active-low segments, bit0=a … bit6=g.
- `dp`  out  1  active-low decimal point; constant 1 (off).
- `anodes`  out  8  active-low digit enables; bit k = digit k (k=0 least significant).

## Operation
- Shadow register `shown[N-1:0]` loads `value` on any edge where `update`=1; otherwise it holds. The display never reads `value` directly.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. On the edge where prescaler = REFRESH_DIV-1, digit index `idx` advances by one, wrapping DIGITS-1 → 0.
- Nibble select: `nib = shown[4*idx +: 4]`, zero-extended when it passes bit N-1.
- Hex decode uses standard glyphs 0–9 and A, b, C, d, E, F. Examples: 0 → 7'b1000000, 1 → 7'b1111001, 8 → 7'b0000000, F → 7'b0001110.
- Blanking: `msd` = index of the highest nonzero nibble of `shown` (0 if `shown`=0). If `blank_zeros`=1 and `idx > msd`, then `anodes` = 8'hFF. Digit 0 is never blanked.
- Anodes: `anodes[idx]`=0 and all other bits are 1. Bits ≥ DIGITS are always 1.
- `segments`, `anodes` and `dp` are registered outputs with no combinational path from inputs.

## Timing
- Reset values: `shown`=0, prescaler=0, `idx`=0, `anodes`=8'hFE, `segments`=7'b1000000, `dp`=1.
- Reset mid-scan: all state returns to reset values at that edge, and the scan restarts at digit 0 with a full REFRESH_DIV slot.
- Output latency is 1 cycle. Outputs at edge k+1 reflect `idx` and `shown` as they stood after edge k.
  - `update` at edge k → new value visible on the active digit at edge k+1.
- Each digit is driven for exactly REFRESH_DIV cycles. The full frame lasts DIGITS·REFRESH_DIV cycles.
- Simultaneous `update` and digit advance on the same edge: both take effect, and the next output uses the new digit with the new value.
- Changing `blank_zeros` takes effect at the next output register update (1 cycle).
- `update` held high continuously: the display tracks `value` with 1-cycle lag.

## Structure
- Package `display_pkg`:
  - `SEG_BLANK` = 7'h7F
  - the 16-entry hex glyph table as localparam constants
  - `MAX_DIGITS` = 8
- Sub-module `hex_to_7seg`: combinational 4-bit → 7-bit active-low decoder using the package table.
- Top level contains:
  - shadow register
  - prescaler
  - digit index
  - leading-zero (`msd`) priority logic
  - output registers

## Test plan
Bench uses REFRESH_DIV=4, N=32 unless noted.
- Reset: assert `reset` for 2 cycles → `anodes`=8'hFE, `segments`=7'b1000000, `dp`=1. After release, `idx` advances every 4 cycles and `anodes` walks FE, FD, FB … 7F, then back to FE.
- Load and scan: `update` pulse with `value`=32'h1234_ABCD, `blank_zeros`=0 → over one frame, digits 0..7 show D, C, b, A, 4, 3, 2, 1 with matching one-hot anodes.
- Blanking: `value`=32'h0000_00F0, `blank_zeros`=1 → digits 0 and 1 show 0 and F; digits 2..7 give `anodes`=8'hFF. With `value`=0, only digit 0 lights and shows '0'.
- Hold: `update`=0 while `value` changes every cycle → display stays at the last captured value for 3 full frames.
- Narrow width: N=10, `value`=10'h3FF → DIGITS=3, showing F, F, 3. `anodes[7:3]` stay 1 for all cycles.
- Reset mid-frame: assert `reset` while `idx`=5 with `shown`≠0 → next edge gives reset values, `shown`=0, and digit 0 is held for a full 4 cycles.
